// File: rtl/ons_calc.sv
// ons_calc: registered 28.5x scaler with round-half-up.
// Y = 28*X + ceil(X/2) for a 6-bit unsigned X, captured one cycle after
// in_valid, qualified by out_valid. The 11-bit result cannot overflow
// (max 1796 at X=63), so there is no saturation or wrap handling.
module ons_calc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [5:0]  X,
  output logic [10:0] Y,
  output logic        out_valid
);

  logic [10:0] x_ext;
  logic [10:0] x_times_28;
  logic [6:0]  x_plus_one;
  logic [6:0]  ceil_half;
  logic [10:0] y_next;

  // 28*X as 32*X - 4*X; the 11-bit width holds 32*63 = 2016 without loss.
  assign x_ext      = {5'b0, X};
  assign x_times_28 = (x_ext << 5) - (x_ext << 2);

  // ceil(X/2) as (X+1)>>1; the 7-bit sum keeps X=63 from wrapping to 0.
  assign x_plus_one = {1'b0, X} + 7'd1;
  assign ceil_half  = x_plus_one >> 1;

  assign y_next = x_times_28 + {4'b0, ceil_half};

  // Result register: loads only on valid input, otherwise holds; valid
  // flag is a one-cycle delayed copy of in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y         <= '0;
      out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering inside this block cannot matter.
      out_valid <= in_valid;
      if (in_valid) begin
        Y <= y_next;
      end
    end
  end

endmodule

// File: tb/tb_ons_calc.sv
// Testbench for ons_calc: stimulus pushes expected {out_valid, Y} per
// clock edge into a scoreboard; a negedge monitor pops and compares.
module tb_ons_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [5:0]  X;
  logic [10:0] Y;
  logic        out_valid;

  typedef struct {
    logic        valid;
    logic [10:0] y;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [10:0] model_y = '0;

  ons_calc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Edge counter used to tag when each expected result becomes visible.
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: 28*X plus half of X rounded up, in plain integer arithmetic.
  function automatic int ref_y(input int x);
    return 28 * x + (x + 1) / 2;
  endfunction

  // Apply one cycle of stimulus just after an edge; the result is due on
  // the following edge.
  task automatic drive(input logic v, input logic [5:0] x, input int exp_y);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    X        = x;
    if (v) model_y = exp_y[10:0];
    e.valid = v;
    e.y     = model_y;
    e.due   = cyc + 1;
    sb_q.push_back(e);
  endtask

  // Monitor: compares each scheduled result on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.due < cyc) begin
          check("stale_entry", e.due, cyc);
        end else begin
          check("out_valid", int'(out_valid), int'(e.valid));
          check("y", int'(Y), int'(e.y));
        end
      end
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   waited;

    // Reset held with a live operand: outputs stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    X        = 6'd63;
    repeat (3) begin
      @(negedge clk);
      check("reset_y", int'(Y), 0);
      check("reset_out_valid", int'(out_valid), 0);
    end

    // Release reset; the next edge captures X=63.
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    model_y = 11'd1796;
    e.valid = 1'b1;
    e.y     = model_y;
    e.due   = cyc + 1;
    sb_q.push_back(e);

    // Hand-computed directed points.
    drive(1'b1, 6'd1,  29);
    drive(1'b1, 6'd2,  57);
    drive(1'b1, 6'd3,  86);
    drive(1'b1, 6'd40, 1140);
    drive(1'b1, 6'd0,  0);
    drive(1'b1, 6'd63, 1796);

    // Sweep 1..40 back-to-back.
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 6'(i), ref_y(i));
    end

    // Hold: capture 10, then idle with a changing operand.
    drive(1'b1, 6'd10, 285);
    drive(1'b0, 6'd50, 0);
    drive(1'b0, 6'd50, 0);
    drive(1'b0, 6'd50, 0);

    // Back-to-back alternation.
    drive(1'b1, 6'd21, 599);
    drive(1'b1, 6'd22, 627);
    drive(1'b1, 6'd21, 599);

    // Mid-stream reset: X=33 is presented, then reset pulses before the
    // capturing edge, so its result must never show up.
    drive(1'b1, 6'd33, 941);
    #2;
    check("pre_reset_y", int'(Y), 599);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("async_reset_y", int'(Y), 0);
    check("async_reset_out_valid", int'(out_valid), 0);
    sb_q.delete();
    model_y = '0;
    #1;
    rst_n = 1'b1;
    e.valid = 1'b0;
    e.y     = 11'd0;
    e.due   = cyc + 1;
    sb_q.push_back(e);
    drive(1'b0, 6'd33, 0);
    drive(1'b0, 6'd33, 0);

    // Capture after the mid-stream reset still works.
    drive(1'b1, 6'd63, 1796);
    drive(1'b0, 6'd0,  0);

    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (sb_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited = waited + 1;
    end
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
